uart_rx_ctrl: RTL and testbench

//  Sequencer/buffer for the 16x-oversampling UART receiver (1 start + 8 data + 1 stop).

---
 rtl/uart_rx_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencer and receive buffer for a 16x-oversampling UART receiver.
// Generates the oversample tick, gates the receiver with a clean drain on disable,
// and holds received bytes in a show-ahead FIFO with sticky overflow/framing status.
// Optional feature macro: UART_RX_TIMEOUT_EN (adds TO_TICKS parameter and rx_timeout).
module uart_rx_ctrl #(
   parameter int DIV_W = 16,
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
`ifdef UART_RX_TIMEOUT_EN
   , parameter int TO_TICKS = 640
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_en,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             clr_err,
   output logic             os_tick,
   output logic             rx_enable,
   input  logic             rx_busy,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic             rx_ferr,
   input  logic             rd_en,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic [CNT_W-1:0] fifo_count,
   output logic             ovf,
   output logic             ferr
`ifdef UART_RX_TIMEOUT_EN
   , output logic           rx_timeout
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {S_OFF, S_RUN, S_DRAIN} state_e;

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic               os_tick_q, os_tick_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               ovf_q, ovf_d, ferr_q, ferr_d;
   logic [7:0]         mem_q [DEPTH];

   logic               active, active_next, tick_hit;
   logic [DIV_W-1:0]   div_m1;
   logic               full, empty, pop, push, wr_try, ovf_set, ferr_set;

   assign active      = (state_q != S_OFF);
   assign active_next = (state_d != S_OFF);
   assign div_m1      = (cfg_div == '0) ? '0 : cfg_div - DIV_W'(1);
   assign tick_hit    = (cnt_q >= div_m1);

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign pop      = rd_en && !empty;
   assign wr_try   = active && rx_valid && !rx_ferr;
   assign push     = wr_try && (!full || pop);
   assign ovf_set  = wr_try && full && !pop;
   assign ferr_set = active && rx_valid && rx_ferr;

   // Enable sequencing: a disable mid-frame waits in DRAIN until the receiver is idle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_OFF:   if (cfg_en) state_d = S_RUN;
         S_RUN:   if (!cfg_en) state_d = rx_busy ? S_DRAIN : S_OFF;
         S_DRAIN: if (!rx_busy) state_d = S_OFF;
         default: state_d = S_OFF;
      endcase
   end

   // Oversample divider: >= compare lets a smaller divisor take effect immediately.
   always_comb begin
      cnt_d     = '0;
      os_tick_d = 1'b0;
      if (active && active_next) begin
         os_tick_d = tick_hit;
         cnt_d     = tick_hit ? '0 : cnt_q + DIV_W'(1);
      end
   end

   // FIFO pointer/occupancy update and sticky flags (a set in the clear cycle wins).
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      ovf_d  = ovf_set  | (ovf_q  & ~clr_err);
      ferr_d = ferr_set | (ferr_q & ~clr_err);
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_OFF;
         cnt_q     <= '0;
         os_tick_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         os_tick_q <= os_tick_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         ferr_q    <= ferr_d;
      end
   end

   // Byte storage; a push at full is only allowed alongside a pop, so the freed slot is reused.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rx_data;
   end

   assign os_tick    = os_tick_q;
   assign rx_enable  = active;
   assign rd_data    = mem_q[rd_ptr_q];
   assign rd_valid   = !empty;
   assign fifo_count = count_q;
   assign ovf        = ovf_q;
   assign ferr       = ferr_q;

`ifdef UART_RX_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_TICKS + 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            to_pulse_q, to_pulse_d;

   // Idle timeout: count ticks while data waits unread; hold at the limit until cleared.
   always_comb begin
      to_cnt_d   = to_cnt_q;
      to_pulse_d = 1'b0;
      if (rx_valid || pop || empty) begin
         to_cnt_d = '0;
      end else if (os_tick_q && (to_cnt_q != TO_W'(TO_TICKS))) begin
         to_cnt_d   = to_cnt_q + TO_W'(1);
         to_pulse_d = (to_cnt_q == TO_W'(TO_TICKS - 1));
      end
   end

   // Timeout counter and pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q   <= '0;
         to_pulse_q <= 1'b0;
      end else begin
         to_cnt_q   <= to_cnt_d;
         to_pulse_q <= to_pulse_d;
      end
   end

   assign rx_timeout = to_pulse_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_uart_rx_ctrl;

   localparam int DIV_W = 16;
   localparam int DEPTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst, cfg_en, clr_err, rx_busy, rx_valid, rx_ferr, rd_en;
   logic [DIV_W-1:0] cfg_div;
   logic [7:0]       rx_data;
   logic             os_tick, rx_enable, rd_valid, ovf, ferr;
   logic [7:0]       rd_data;
   logic [CNT_W-1:0] fifo_count;

   int n_vec = 0;
   int n_bad = 0;

   // Behavioural model state
   bit [7:0] q[$];
   bit       ovf_m, ferr_m, en_m, drain_m, tick_m;
   int       k;

   uart_rx_ctrl #(.DIV_W(DIV_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_div(cfg_div), .clr_err(clr_err),
      .os_tick(os_tick), .rx_enable(rx_enable), .rx_busy(rx_busy), .rx_valid(rx_valid),
      .rx_data(rx_data), .rx_ferr(rx_ferr), .rd_en(rd_en), .rd_data(rd_data),
      .rd_valid(rd_valid), .fifo_count(fifo_count), .ovf(ovf), .ferr(ferr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the model with the inputs present at the coming edge, clock, then compare.
   task automatic cyc();
      bit push, pop, prev;
      int dv;
      push = 0;
      if (rst) begin
         q.delete();
         ovf_m = 0; ferr_m = 0; en_m = 0; drain_m = 0; k = 0; tick_m = 0;
      end else begin
         pop = rd_en && (q.size() > 0);
         if (clr_err) begin ovf_m = 0; ferr_m = 0; end
         if (en_m && rx_valid) begin
            if (rx_ferr) ferr_m = 1;
            else if (q.size() < DEPTH || pop) push = 1;
            else ovf_m = 1;
         end
         if (pop) void'(q.pop_front());
         if (push) q.push_back(rx_data);
         prev = en_m;
         if (!en_m) begin
            if (cfg_en) en_m = 1;
         end else if (drain_m) begin
            if (!rx_busy) begin en_m = 0; drain_m = 0; end
         end else if (!cfg_en) begin
            if (rx_busy) drain_m = 1; else en_m = 0;
         end
         if (en_m && prev) k++; else k = 0;
         dv = (cfg_div == 0) ? 1 : int'(cfg_div);
         tick_m = en_m && prev && ((k % dv) == 0);
      end
      @(posedge clk);
      #1;
      chk("rx_enable", 32'(rx_enable), 32'(en_m));
      chk("os_tick", 32'(os_tick), 32'(tick_m));
      chk("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("ovf", 32'(ovf), 32'(ovf_m));
      chk("ferr", 32'(ferr), 32'(ferr_m));
      if (q.size() > 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
   endtask

   task automatic push_byte(input logic [7:0] d, input logic fe);
      rx_valid = 1; rx_data = d; rx_ferr = fe;
      cyc();
      rx_valid = 0; rx_ferr = 0;
   endtask

   initial begin
      rst = 1; cfg_en = 0; cfg_div = 16'd4; clr_err = 0; rx_busy = 0;
      rx_valid = 0; rx_ferr = 0; rx_data = 8'h00; rd_en = 0;
      // Reset state
      repeat (3) cyc();
      chk("reset_count", 32'(fifo_count), 32'd0);
      chk("reset_valid", 32'(rd_valid), 32'd0);
      rst = 0;
      cyc();

      // T1: divisor 4 then 0
      cfg_en = 1;
      repeat (14) cyc();
      cfg_div = 16'd0;
      repeat (5) cyc();
      chk("t1_tick_div0", 32'(os_tick), 32'd1);
      cfg_en = 0;
      repeat (2) cyc();
      chk("t1_off_tick", 32'(os_tick), 32'd0);

      // rx_valid while OFF is ignored
      push_byte(8'h99, 0);
      cyc();
      chk("off_ignore", 32'(fifo_count), 32'd0);

      // T2: ordered push/pop
      cfg_div = 16'd1; cfg_en = 1;
      repeat (2) cyc();
      push_byte(8'h55, 0);
      chk("t2_latency", 32'(rd_data), 32'h55);
      push_byte(8'hA3, 0);
      push_byte(8'h0F, 0);
      chk("t2_count3", 32'(fifo_count), 32'd3);
      rd_en = 1;
      repeat (3) cyc();
      rd_en = 0;
      chk("t2_empty", 32'(rd_valid), 32'd0);
      rd_en = 1; cyc(); rd_en = 0;   // pop when empty is harmless

      // T3: overflow
      for (int i = 0; i <= DEPTH; i++) push_byte(8'($urandom), 0);
      chk("t3_full", 32'(fifo_count), 32'(DEPTH));
      chk("t3_ovf", 32'(ovf), 32'd1);
      clr_err = 1; cyc(); clr_err = 0;
      chk("t3_clr", 32'(ovf), 32'd0);

      // T4: push+pop at full
      rd_en = 1; push_byte(8'hC7, 0); rd_en = 0;
      chk("t4_count", 32'(fifo_count), 32'(DEPTH));
      chk("t4_noovf", 32'(ovf), 32'd0);

      // T5: framing error, then clear coinciding with a new error
      push_byte(8'hFF, 1);
      chk("t5_ferr", 32'(ferr), 32'd1);
      clr_err = 1; push_byte(8'h12, 1); clr_err = 0;
      chk("t5_setwins", 32'(ferr), 32'd1);

      // Drain, then push+pop at empty
      rd_en = 1; repeat (DEPTH) cyc(); rd_en = 0;
      rd_en = 1; push_byte(8'h6E, 0); rd_en = 0;
      chk("empty_pushpop", 32'(fifo_count), 32'd1);
      rd_en = 1; cyc(); rd_en = 0;

      // T6: disable mid-frame
      rx_busy = 1; cfg_en = 0;
      repeat (3) cyc();
      chk("t6_drain_en", 32'(rx_enable), 32'd1);
      cfg_en = 1; push_byte(8'h3C, 0); cfg_en = 0;
      rx_busy = 0;
      repeat (3) cyc();
      chk("t6_off", 32'(rx_enable), 32'd0);
      chk("t6_retain", 32'(rd_data), 32'h3C);

      // Randomized traffic with occasional reset
      rst = 1; cyc(); rst = 0;
      for (int ph = 0; ph < 4; ph++) begin
         cfg_en = 0; rx_busy = 0;
         repeat (3) cyc();
         cfg_div = 16'($urandom_range(0, 5));
         cfg_en = 1;
         for (int c = 0; c < 150; c++) begin
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            rx_ferr  = ($urandom_range(0, 7) == 0);
            rd_en    = ($urandom_range(0, 2) == 0);
            clr_err  = ($urandom_range(0, 15) == 0);
            rx_busy  = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 19) == 0) cfg_en = ~cfg_en;
            rst      = ($urandom_range(0, 99) == 0);
            cyc();
         end
         rst = 0; rx_valid = 0; rx_ferr = 0; rd_en = 0; clr_err = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
